// File: rtl/alu_pkg.sv
// Shared opcode encoding and default operand width for the 8-bit ALU.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 8;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_DIV  = 4'h3,
        OP_INC  = 4'h4,
        OP_DEC  = 4'h5,
        OP_AND  = 4'h6,
        OP_OR   = 4'h7,
        OP_NOT  = 4'h8,
        OP_XOR  = 4'h9,
        OP_XNOR = 4'hA,
        OP_NAND = 4'hB,
        OP_NOR  = 4'hC,
        OP_SHL  = 4'hD,
        OP_SHR  = 4'hE,
        OP_RSVD = 4'hF
    } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: next result and carry/borrow/overflow flag from opcode and operands.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic [3:0]         i_opcode,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_result,
    output logic               o_carry
);

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH:0]     w_inc;
    logic [WIDTH:0]     w_dec;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_logic;
    logic               w_is_logic;
    logic               w_b_zero;

    // Bit WIDTH of the extended differences is the borrow.
    assign w_sum    = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff   = {1'b0, i_a} - {1'b0, i_b};
    assign w_inc    = {1'b0, i_a} + (WIDTH+1)'(1);
    assign w_dec    = {1'b0, i_a} - (WIDTH+1)'(1);
    assign w_prod   = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
    assign w_b_zero = (i_b == '0);
    assign w_quot   = w_b_zero ? '0 : i_a / i_b;
    assign w_rem    = w_b_zero ? '0 : i_a % i_b;

    always_comb begin
        w_logic    = '0;
        w_is_logic = 1'b1;
        case (alu_op_e'(i_opcode))
            OP_AND:  w_logic = i_a & i_b;
            OP_OR:   w_logic = i_a | i_b;
            OP_NOT:  w_logic = ~i_a;
            OP_XOR:  w_logic = i_a ^ i_b;
            OP_XNOR: w_logic = ~(i_a ^ i_b);
            OP_NAND: w_logic = ~(i_a & i_b);
            OP_NOR:  w_logic = ~(i_a | i_b);
            default: w_is_logic = 1'b0;
        endcase
    end

    always_comb begin
        o_result = '0;
        o_carry  = 1'b0;
        case (alu_op_e'(i_opcode))
            OP_ADD: begin
                o_result = {{(WIDTH-1){1'b0}}, w_sum};
                o_carry  = w_sum[WIDTH];
            end
            OP_SUB: begin
                o_result = {{WIDTH{1'b0}}, w_diff[WIDTH-1:0]};
                o_carry  = w_diff[WIDTH];
            end
            OP_MUL: begin
                o_result = w_prod;
                o_carry  = |w_prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                o_result = {w_rem, w_quot};
                o_carry  = w_b_zero;
            end
            OP_INC: begin
                o_result = {{(WIDTH-1){1'b0}}, w_inc};
                o_carry  = w_inc[WIDTH];
            end
            OP_DEC: begin
                o_result = {{WIDTH{1'b0}}, w_dec[WIDTH-1:0]};
                o_carry  = w_dec[WIDTH];
            end
            OP_SHL: begin
                o_result = {{WIDTH{1'b0}}, i_a[WIDTH-2:0], 1'b0};
                o_carry  = i_a[WIDTH-1];
            end
            OP_SHR: begin
                o_result = {{WIDTH{1'b0}}, 1'b0, i_a[WIDTH-1:1]};
                o_carry  = i_a[0];
            end
            default: begin
                if (w_is_logic) begin
                    o_result = {{WIDTH{1'b0}}, w_logic};
                end
            end
        endcase
    end

endmodule

// File: rtl/alu_8_bit.sv
// Registered ALU top: captures the core's result, carry flag and derived zero flag each cycle.
module alu_8_bit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         opcode,
    input  logic [WIDTH-1:0]   operand1,
    input  logic [WIDTH-1:0]   operand2,
    output logic [2*WIDTH-1:0] result,
    output logic               c_flag,
    output logic               z_flag
);

    logic [2*WIDTH-1:0] w_result;
    logic               w_carry;
    logic               w_zero;
    logic [2*WIDTH-1:0] r_result;
    logic               r_c_flag;
    logic               r_z_flag;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .i_opcode (opcode),
        .i_a      (operand1),
        .i_b      (operand2),
        .o_result (w_result),
        .o_carry  (w_carry)
    );

    assign w_zero = (w_result == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_c_flag <= 1'b0;
            r_z_flag <= 1'b0;
        end else begin
            r_result <= w_result;
            r_c_flag <= w_carry;
            r_z_flag <= w_zero;
        end
    end

    assign result = r_result;
    assign c_flag = r_c_flag;
    assign z_flag = r_z_flag;

endmodule

// File: tb/tb_alu_8_bit.sv
// Self-checking bench for alu_8_bit: directed spec vectors plus randomized ops against a behavioural model.
module tb_alu_8_bit;

    typedef struct packed {
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] r;
        logic        c;
        logic        z;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  opcode;
    logic [7:0]  operand1;
    logic [7:0]  operand2;
    logic [15:0] result;
    logic        c_flag;
    logic        z_flag;

    int n_vec;
    int n_err;

    alu_8_bit #(
        .WIDTH (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .opcode   (opcode),
        .operand1 (operand1),
        .operand2 (operand2),
        .result   (result),
        .c_flag   (c_flag),
        .z_flag   (z_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model straight from the opcode table, in plain integer arithmetic.
    function automatic void ref_model(input int op, input int a, input int b,
                                      output logic [15:0] r, output logic c, output logic z);
        int res;
        bit cy;
        res = 0;
        cy  = 0;
        case (op)
            0:  begin res = a + b; cy = (res > 255); end
            1:  begin res = (a - b + 256) % 256; cy = (a < b); end
            2:  begin res = a * b; cy = (res > 255); end
            3:  begin
                    if (b == 0) begin res = 0; cy = 1; end
                    else res = (a % b) * 256 + a / b;
                end
            4:  begin res = a + 1; cy = (a == 255); end
            5:  begin res = (a + 255) % 256; cy = (a == 0); end
            6:  res = a & b;
            7:  res = a | b;
            8:  res = 255 - a;
            9:  res = a ^ b;
            10: res = 255 - (a ^ b);
            11: res = 255 - (a & b);
            12: res = 255 - (a | b);
            13: begin res = (a * 2) % 256; cy = (a >= 128); end
            14: begin res = a / 2; cy = (a % 2 == 1); end
            default: res = 0;
        endcase
        r = 16'(res);
        c = cy;
        z = (res == 0);
    endfunction

    task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        opcode   = op;
        operand1 = a;
        operand2 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        opcode = 4'h0; operand1 = 8'h00; operand2 = 8'h00;
        #2;
        n_vec++;
        if (result !== 16'h0000 || c_flag !== 1'b0 || z_flag !== 1'b0) begin
            n_err++;
            $display("FAIL reset_initial: got r=%h c=%b z=%b, expected r=0000 c=0 z=0",
                     result, c_flag, z_flag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'h0, 8'hFF, 8'h01);
        // Assert reset between edges: outputs must clear without waiting for a clock.
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (result !== 16'h0000 || c_flag !== 1'b0 || z_flag !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: got r=%h c=%b z=%b, expected r=0000 c=0 z=0",
                     result, c_flag, z_flag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'h0, 8'h33, 8'h0C);
        n_vec++;
        if (result !== 16'h003F || c_flag !== 1'b0 || z_flag !== 1'b0) begin
            n_err++;
            $display("FAIL reset_then_add: got r=%h c=%b z=%b, expected r=003f c=0 z=0",
                     result, c_flag, z_flag);
        end
    endtask

    task automatic test_arith();
        vec_t tbl[9];
        tbl = '{
            '{4'h1, 8'h33, 8'h0C, 16'h0027, 1'b0, 1'b0},
            '{4'h2, 8'h33, 8'h0C, 16'h0264, 1'b1, 1'b0},
            '{4'h3, 8'h33, 8'h0C, 16'h0304, 1'b0, 1'b0},
            '{4'h3, 8'h33, 8'h00, 16'h0000, 1'b1, 1'b1},
            '{4'h0, 8'hFF, 8'h01, 16'h0100, 1'b1, 1'b0},
            '{4'h1, 8'h0C, 8'h33, 16'h00D9, 1'b1, 1'b0},
            '{4'h4, 8'hFF, 8'h00, 16'h0100, 1'b1, 1'b0},
            '{4'h5, 8'h00, 8'h00, 16'h00FF, 1'b1, 1'b0},
            '{4'h5, 8'h01, 8'h00, 16'h0000, 1'b0, 1'b1}
        };
        foreach (tbl[i]) begin
            drive(tbl[i].op, tbl[i].a, tbl[i].b);
            n_vec++;
            if (result !== tbl[i].r || c_flag !== tbl[i].c || z_flag !== tbl[i].z) begin
                n_err++;
                $display("FAIL arith[%0d] op=%h a=%h b=%h: got r=%h c=%b z=%b, expected r=%h c=%b z=%b",
                         i, tbl[i].op, tbl[i].a, tbl[i].b, result, c_flag, z_flag,
                         tbl[i].r, tbl[i].c, tbl[i].z);
            end
        end
    endtask

    task automatic test_logic();
        vec_t tbl[7];
        tbl = '{
            '{4'h6, 8'h33, 8'hCC, 16'h0000, 1'b0, 1'b1},
            '{4'h7, 8'h33, 8'hCC, 16'h00FF, 1'b0, 1'b0},
            '{4'h8, 8'h33, 8'hCC, 16'h00CC, 1'b0, 1'b0},
            '{4'h9, 8'h33, 8'hCC, 16'h00FF, 1'b0, 1'b0},
            '{4'hA, 8'h33, 8'hCC, 16'h0000, 1'b0, 1'b1},
            '{4'hB, 8'h33, 8'hCC, 16'h00FF, 1'b0, 1'b0},
            '{4'hC, 8'h33, 8'hCC, 16'h0000, 1'b0, 1'b1}
        };
        foreach (tbl[i]) begin
            drive(tbl[i].op, tbl[i].a, tbl[i].b);
            n_vec++;
            if (result !== tbl[i].r || c_flag !== tbl[i].c || z_flag !== tbl[i].z) begin
                n_err++;
                $display("FAIL logic[%0d] op=%h: got r=%h c=%b z=%b, expected r=%h c=%b z=%b",
                         i, tbl[i].op, result, c_flag, z_flag, tbl[i].r, tbl[i].c, tbl[i].z);
            end
        end
    endtask

    task automatic test_shift_rsvd();
        vec_t tbl[3];
        tbl = '{
            '{4'hD, 8'hB3, 8'h00, 16'h0066, 1'b1, 1'b0},
            '{4'hE, 8'h33, 8'h00, 16'h0019, 1'b1, 1'b0},
            '{4'hF, 8'h33, 8'h0C, 16'h0000, 1'b0, 1'b1}
        };
        foreach (tbl[i]) begin
            drive(tbl[i].op, tbl[i].a, tbl[i].b);
            n_vec++;
            if (result !== tbl[i].r || c_flag !== tbl[i].c || z_flag !== tbl[i].z) begin
                n_err++;
                $display("FAIL shift_rsvd[%0d] op=%h: got r=%h c=%b z=%b, expected r=%h c=%b z=%b",
                         i, tbl[i].op, result, c_flag, z_flag, tbl[i].r, tbl[i].c, tbl[i].z);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] er;
        logic        ec;
        logic        ez;
        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 8'($urandom);
            b  = (i % 8 == 0) ? 8'h00 : 8'($urandom);
            ref_model(int'(op), int'(a), int'(b), er, ec, ez);
            drive(op, a, b);
            n_vec++;
            if (result !== er || c_flag !== ec || z_flag !== ez) begin
                n_err++;
                $display("FAIL random[%0d] op=%h a=%h b=%h: got r=%h c=%b z=%b, expected r=%h c=%b z=%b",
                         i, op, a, b, result, c_flag, z_flag, er, ec, ez);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] er;
        logic        ec;
        logic        ez;
        logic [15:0] prev_r;
        logic        prev_c;
        logic        prev_z;
        ref_model(int'(opcode), int'(operand1), int'(operand2), prev_r, prev_c, prev_z);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            opcode   = 4'($urandom_range(0, 15));
            operand1 = 8'($urandom);
            operand2 = 8'($urandom);
            ref_model(int'(opcode), int'(operand1), int'(operand2), er, ec, ez);
            #1;
            // New inputs must not show up before the next edge.
            n_vec++;
            if (result !== prev_r || c_flag !== prev_c || z_flag !== prev_z) begin
                n_err++;
                $display("FAIL b2b_hold[%0d]: got r=%h c=%b z=%b, expected r=%h c=%b z=%b",
                         i, result, c_flag, z_flag, prev_r, prev_c, prev_z);
            end
            @(posedge clk);
            #1;
            n_vec++;
            if (result !== er || c_flag !== ec || z_flag !== ez) begin
                n_err++;
                $display("FAIL b2b[%0d]: got r=%h c=%b z=%b, expected r=%h c=%b z=%b",
                         i, result, c_flag, z_flag, er, ec, ez);
            end
            prev_r = er;
            prev_c = ec;
            prev_z = ez;
        end
    endtask

    task automatic test_reset_midstream();
        drive(4'h2, 8'hFF, 8'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (result !== 16'h0000 || c_flag !== 1'b0 || z_flag !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_async: got r=%h c=%b z=%b, expected r=0000 c=0 z=0",
                     result, c_flag, z_flag);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (result !== 16'h0000 || c_flag !== 1'b0 || z_flag !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_hold: got r=%h c=%b z=%b, expected r=0000 c=0 z=0",
                     result, c_flag, z_flag);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        opcode   = 4'h7;
        operand1 = 8'h50;
        operand2 = 8'h05;
        #1;
        n_vec++;
        if (result !== 16'h0000 || c_flag !== 1'b0 || z_flag !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_release: got r=%h c=%b z=%b, expected r=0000 c=0 z=0",
                     result, c_flag, z_flag);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (result !== 16'h0055 || c_flag !== 1'b0 || z_flag !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_resume: got r=%h c=%b z=%b, expected r=0055 c=0 z=0",
                     result, c_flag, z_flag);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_arith();
        test_logic();
        test_shift_rsvd();
        test_random();
        test_back_to_back();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_8_bit.md
Name: alu_8_bit

Overview:
- Registered 8-bit arithmetic/logic unit.
- Takes a 4-bit opcode and two 8-bit operands; produces a 16-bit result plus carry and zero flags.
- Result and flags are captured on the rising clock edge.
- Used as a simple datapath execution unit; operands and opcode come straight from the controller.

Parameters:
- WIDTH, 8, operand width; result width is 2*WIDTH. Only 8 is verified.

Ports:
- clk  in  1  system clock, rising-edge active
- rst_n  in  1  reset, asynchronous assert, active-low
- opcode  in  4  operation select
- operand1  in  8  operand A
- operand2  in  8  operand B (ignored by unary ops)
- result  out  16  registered result
- c_flag  out  1  registered carry/borrow/overflow flag
- z_flag  out  1  registered zero flag

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-low.
  - rst_n low forces result=16'h0000, c_flag=0, z_flag=0 immediately; these hold until rst_n is high at a rising clk.
  - Reset asserted mid-operation discards any in-flight result.
- Timing:
  - Latency 1 cycle: inputs sampled at rising edge N appear on the outputs after edge N.
  - Outputs hold until the next edge. No handshake; a new operation every cycle.
- z_flag = (next result == 16'h0000), registered together with result.
- Unless stated otherwise, result[15:8]=0 and c_flag=0.
- Opcode map:
  - 0000 ADD: result = {7'b0, A+B} as a 9-bit sum; c_flag = carry out (bit 8).
  - 0001 SUB: result[7:0] = A-B mod 256; c_flag = borrow (A<B).
  - 0010 MUL: result = A*B as a full 16-bit unsigned product; c_flag = |result[15:8].
  - 0011 DIV: result[7:0] = A/B, result[15:8] = A%B, unsigned.
    - B==0: result=16'h0000, c_flag=1 (divide error), z_flag=1.
  - 0100 INC: result = {7'b0, A+1} as a 9-bit sum; c_flag = carry (A==8'hFF).
  - 0101 DEC: result[7:0] = A-1 mod 256; c_flag = borrow (A==0).
  - 0110 AND: A&B.  0111 OR: A|B.  1000 NOT: ~A.  1001 XOR: A^B.
  - 1010 XNOR: ~(A^B).  1011 NAND: ~(A&B).  1100 NOR: ~(A|B).
  - All logical results go in result[7:0]; c_flag=0.
  - 1101 SHL: result[7:0] = {A[6:0],1'b0}; c_flag = A[7].
  - 1110 SHR: result[7:0] = {1'b0,A[7:1]}; c_flag = A[0].
  - 1111 reserved: result=0, c_flag=0, z_flag=1.
- Operand inputs containing X/Z are not qualified.
- Operands are always interpreted as unsigned.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams/enum OP_ADD..OP_SHR, OP_RSVD.
  - WIDTH default.
- One natural sub-module: alu_core, purely combinational. It computes next result and c_flag from opcode/operands.
- The top level registers result, c_flag and z_flag, and derives z_flag from alu_core's output.

Test Plan:
- Reset: drive rst_n=0 between clock edges -> outputs 0/0/0 immediately. Release, then ADD A=8'h33 B=8'h0C -> result 16'h003F, c=0, z=0 one cycle later.
- Arithmetic, A=8'h33 B=8'h0C:
  - SUB -> 16'h0027, c=0.
  - MUL -> 16'h0264, c=1.
  - DIV -> 16'h0304, c=0.
  - DIV with B=0 -> 16'h0000, c=1, z=1.
- Carry/borrow edges:
  - ADD FF+01 -> 16'h0100, c=1, z=0.
  - SUB 0C-33 -> 16'h00D9, c=1.
  - INC FF -> 16'h0100, c=1.
  - DEC 00 -> 16'h00FF, c=1.
  - DEC 01 -> 16'h0000, z=1.
- Logic, A=8'h33 B=8'hCC: AND 0000 z=1, OR 00FF, NOT(A) 00CC, XOR 00FF, XNOR 0000 z=1, NAND 00FF, NOR 0000 z=1; c=0 throughout.
- Shifts and reserved:
  - SHL A=8'hB3 -> 16'h0066, c=1.
  - SHR A=8'h33 -> 16'h0019, c=1.
  - Opcode 1111 -> 16'h0000, c=0, z=1.
- Back-to-back opcodes on consecutive edges: each result appears exactly one cycle after its inputs. Then assert rst_n mid-stream -> outputs clear asynchronously, with no stale result after release.
